sram_mem_ctrl: RTL and testbench

//   MEM-stage responder for data-memory requests from the EXE/MEM pipeline register.

---
 rtl/sram_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory responder: 32-bit loads/stores as two 16-bit SRAM phases.
// Optional MEM_RANGE_CHECK_EN adds mem_err and short-circuits out-of-range accesses.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic               freeze,
`ifdef MEM_RANGE_CHECK_EN
  output logic               mem_err,
`endif
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_O,
  input  logic [15:0]        SRAM_DQ_I,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int WW = SRAM_AW - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wa_q, wa_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     offs;
  logic [WW-1:0]   wa_in;
  logic            req;
  logic            last;
  logic            unused_bits;

  assign offs        = address - 32'(BASE_ADDR);
  assign wa_in       = offs[SRAM_AW:2];
  assign req         = MEM_R_EN | MEM_W_EN;
  assign last        = (cnt_q == CW'(WAIT_CYCLES));
  assign unused_bits = ^{offs[31:SRAM_AW+1], offs[1:0]};

`ifdef MEM_RANGE_CHECK_EN
  logic err_q, err_d;
  logic bad_addr;

  assign bad_addr = (address < 32'(BASE_ADDR)) | (|offs[31:SRAM_AW+1]);
  assign mem_err  = (state_q == DONE) & err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef MEM_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wa_d    = wa_in;
          wdata_d = writeData;
          wr_d    = MEM_W_EN;
          cnt_d   = '0;
          state_d = LOW;
`ifdef MEM_RANGE_CHECK_EN
          err_d   = bad_addr;
          // Out-of-range: skip both SRAM phases entirely
          if (bad_addr) begin
            state_d = DONE;
            if (!MEM_W_EN) rdata_d = 32'hDEAD_BEEF;
          end
`endif
        end
      end
      LOW: begin
        if (last) begin
          cnt_d   = '0;
          state_d = HIGH;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    SRAM_ADDR  = '0;
    SRAM_DQ_O  = '0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    unique case (state_q)
      LOW: begin
        SRAM_ADDR = {wa_q, 1'b0};
        if (wr_q) begin
          SRAM_DQ_O  = wdata_q[15:0];
          SRAM_DQ_OE = 1'b1;
          SRAM_WE_N  = 1'b0;
        end
      end
      HIGH: begin
        SRAM_ADDR = {wa_q, 1'b1};
        if (wr_q) begin
          SRAM_DQ_O  = wdata_q[31:16];
          SRAM_DQ_OE = 1'b1;
          SRAM_WE_N  = 1'b0;
        end
      end
      default: begin
        SRAM_ADDR = '0;
      end
    endcase
  end

  assign ready    = (state_q == DONE);
  assign freeze   = req & (state_q != DONE);
  assign readData = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef MEM_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: SRAM array model plus word-level reference memory.
// Randomized accesses are scored against latency, data and strobe expectations.
module tb_sram_mem_ctrl;

  localparam int WAIT = 1;
  localparam int AW   = 18;
  localparam int BASE = 1024;
  localparam int LAT  = 2 * (WAIT + 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN;
  logic          MEM_W_EN;
  logic [31:0]   address;
  logic [31:0]   writeData;
  logic [31:0]   readData;
  logic          ready;
  logic          freeze;
  logic [AW-1:0] SRAM_ADDR;
  logic [15:0]   SRAM_DQ_O;
  logic [15:0]   SRAM_DQ_I;
  logic          SRAM_DQ_OE;
  logic          SRAM_WE_N;
`ifdef MEM_RANGE_CHECK_EN
  logic          mem_err;
`endif

  int errors = 0;
  int checks = 0;

  bit [15:0]   sram [0:(1<<AW)-1];
  bit [31:0]   ref_mem [int];
  logic [31:0] exp_rd;

  sram_mem_ctrl #(
    .WAIT_CYCLES(WAIT),
    .SRAM_AW(AW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .address(address),
    .writeData(writeData),
    .readData(readData),
    .ready(ready),
    .freeze(freeze),
`ifdef MEM_RANGE_CHECK_EN
    .mem_err(mem_err),
`endif
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_O(SRAM_DQ_O),
    .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  assign SRAM_DQ_I = sram[SRAM_ADDR];

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ_O;
  end

  function automatic int wa_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'(BASE);
    return int'((o >> 2) & ((32'd1 << (AW - 1)) - 1));
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'(BASE);
    return (a >= 32'(BASE)) && ((o >> 2) < (32'd1 << (AW - 1)));
  endfunction

  function automatic logic [31:0] ref_get(input int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : 32'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    address = 32'd1028;
    writeData = 32'hFFFF_FFFF;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (SRAM_WE_N !== 1'b1 || ready !== 1'b0 ||
          readData !== 32'd0 || SRAM_DQ_OE !== 1'b0 ||
          SRAM_ADDR !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: we_n=%b ready=%b rd=%h oe=%b addr=%h want 1 0 0 0 0",
                 i, SRAM_WE_N, ready, readData, SRAM_DQ_OE, SRAM_ADDR);
      end
      if (i < 2) @(posedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    exp_rd = 32'd0;
  endtask

  task automatic test_idle();
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    address = $urandom;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || freeze !== 1'b0 ||
        SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin
      errors++;
      $display("FAIL idle: ready=%b freeze=%b we_n=%b oe=%b want 0 0 1 0",
               ready, freeze, SRAM_WE_N, SRAM_DQ_OE);
    end
  endtask

  // Caller keeps enables asserted after return, so consecutive calls are back-to-back.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    bit err;
    bit wr;
    int exp_lat;
    int lat;
    int we_cnt;
    int exp_we;
    int wa;
    bit fz_bad;
    bit oe_bad;
    bit fz_done;
`ifdef MEM_RANGE_CHECK_EN
    logic err_seen;
`endif
    err = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    err = !in_range(a);
`endif
    wr = w;
    wa = wa_of(a);
    exp_lat = err ? 1 : LAT;
    exp_we = (wr && !err) ? 2 * (WAIT + 1) : 0;
    if (wr) begin
      if (!err) ref_mem[wa] = d;
    end else begin
      exp_rd = err ? 32'hDEAD_BEEF : ref_get(wa);
    end
    @(posedge clk);
    #1;
    MEM_W_EN = w;
    MEM_R_EN = r;
    address = a;
    writeData = d;
    lat = -1;
    we_cnt = 0;
    fz_bad = 1'b0;
    oe_bad = 1'b0;
    fz_done = 1'b1;
`ifdef MEM_RANGE_CHECK_EN
    err_seen = 1'bx;
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!SRAM_WE_N) begin
        we_cnt++;
        if (SRAM_DQ_OE !== 1'b1) oe_bad = 1'b1;
      end
      if (ready === 1'b1) begin
        lat = k;
        fz_done = freeze;
`ifdef MEM_RANGE_CHECK_EN
        err_seen = mem_err;
`endif
        break;
      end
      if (freeze !== 1'b1) fz_bad = 1'b1;
      @(posedge clk);
      #1;
      address = $urandom;
      writeData = $urandom;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d (-1 = timeout)", nm, lat, exp_lat);
    end
    checks++;
    if (fz_bad || fz_done !== 1'b0) begin
      errors++;
      $display("FAIL %s freeze: early_drop=%b at_ready=%b want 0 0", nm, fz_bad, fz_done);
    end
    checks++;
    if (readData !== exp_rd) begin
      errors++;
      $display("FAIL %s readData: got %h want %h", nm, readData, exp_rd);
    end
    checks++;
    if (we_cnt != exp_we || oe_bad) begin
      errors++;
      $display("FAIL %s strobe: we_low=%0d oe_bad=%b want %0d 0", nm, we_cnt, oe_bad, exp_we);
    end
    if (wr && !err) begin
      checks++;
      if (sram[2*wa] !== d[15:0] || sram[2*wa+1] !== d[31:16]) begin
        errors++;
        $display("FAIL %s sram: hw%0d=%h hw%0d=%h want %h %h", nm, 2*wa, sram[2*wa],
                 2*wa+1, sram[2*wa+1], d[15:0], d[31:16]);
      end
    end
`ifdef MEM_RANGE_CHECK_EN
    checks++;
    if (err_seen !== err) begin
      errors++;
      $display("FAIL %s mem_err: got %b want %b", nm, err_seen, err);
    end
`endif
  endtask

  task automatic test_store_load();
    access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, "store1028");
    test_idle();
    access(1'b0, 1'b1, 32'd1028, 32'h0, "load1028");
    test_idle();
  endtask

  task automatic test_both_enables();
    access(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, "both1032");
    access(1'b0, 1'b1, 32'd1032, 32'h0, "load1032");
    test_idle();
  endtask

  task automatic test_reset_mid();
    int wa;
    wa = 100;
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    address = 32'(BASE + 4 * wa);
    writeData = $urandom;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    checks++;
    if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== AW'(2 * wa + 1)) begin
      errors++;
      $display("FAIL rstmid_high: we_n=%b addr=%0d want 0 %0d", SRAM_WE_N, SRAM_ADDR, 2*wa+1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rd = 32'd0;
    @(negedge clk);
    checks++;
    if (SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0 || ready !== 1'b0 ||
        SRAM_ADDR !== '0 || readData !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_idle: we_n=%b oe=%b ready=%b addr=%h rd=%h want 1 0 0 0 0",
               SRAM_WE_N, SRAM_DQ_OE, ready, SRAM_ADDR, readData);
    end
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (ready !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
        errors++;
        $display("FAIL rstmid_noready: pulses=%0d want 0", pulses);
      end
    end
    access(1'b0, 1'b1, 32'd1028, 32'h0, "load_after_rst");
    test_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = 32'(BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3));
      access(op != 0, op != 1, a, $urandom, "rand");
      if ($urandom_range(0, 3) == 0) test_idle();
    end
    test_idle();
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    a = 32'(BASE + 4 * ((1 << (AW - 1)) + 7));
    access(1'b1, 1'b0, a, 32'hCAFE_F00D, "wrap_store");
    access(1'b0, 1'b1, 32'(BASE + 28), 32'h0, "wrap_load");
    test_idle();
  endtask

`ifdef MEM_RANGE_CHECK_EN
  task automatic test_range();
    access(1'b0, 1'b1, 32'd4, 32'h0, "range_load_low");
    access(1'b1, 1'b0, 32'd8, 32'h1111_2222, "range_store_low");
    access(1'b0, 1'b1, 32'(BASE + 4 * (1 << (AW - 1))), 32'h0, "range_load_ovf");
    access(1'b0, 1'b1, 32'd1028, 32'h0, "range_ok");
    test_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_both_enables();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
`ifdef MEM_RANGE_CHECK_EN
    test_range();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
